// File: rtl/alu_4bit.sv
// Registered WIDTH-bit ALU: eight ops, carry/overflow/zero/negative flags.
// One-cycle latency, no enable; async active-low reset.
module alu_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] ALUout,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int M = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;

  // Extra top bit holds carry-out (ADD) or borrow (SUB).
  assign sum = {1'b0, ina} + {1'b0, inb};
  assign dif = {1'b0, ina} - {1'b0, inb};

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    unique case (1'b1)
      (opcode == OP_ADD): begin
        res   = sum[M:0];
        res_c = sum[WIDTH];
        res_v = (ina[M] == inb[M]) && (sum[M] != ina[M]);
      end
      (opcode == OP_SUB): begin
        res   = dif[M:0];
        res_c = dif[WIDTH];
        res_v = (ina[M] != inb[M]) && (dif[M] != ina[M]);
      end
      (opcode == OP_AND): res = ina & inb;
      (opcode == OP_OR):  res = ina | inb;
      (opcode == OP_XOR): res = ina ^ inb;
      (opcode == OP_NOT): res = ~ina;
      (opcode == OP_SHL): begin
        res   = {ina[M-1:0], 1'b0};
        res_c = ina[M];
      end
      (opcode == OP_SHR): begin
        res   = {1'b0, ina[M:1]};
        res_c = ina[0];
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUout   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      negative <= 1'b0;
    end else begin
      ALUout   <= res;
      carry    <= res_c;
      overflow <= res_v;
      zero     <= (res == '0);
      negative <= res[M];
    end
  end

endmodule

// File: tb/tb_alu_4bit.sv
// Directed bench for alu_4bit: hand-computed vectors,
// immediate assertions, async reset behaviour.
module tb_alu_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] ina;
  logic [3:0] inb;
  logic [2:0] opcode;
  logic [3:0] ALUout;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       negative;

  int compared;
  int mismatched;

  alu_4bit #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ina      (ina),
    .inb      (inb),
    .opcode   (opcode),
    .ALUout   (ALUout),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string    tag,
    input logic [3:0] r,
    input logic     c,
    input logic     v,
    input logic     z,
    input logic     n
  );
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {ALUout, carry, overflow, zero, negative};
    exp = {r, c, v, z, n};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b (ALUout,c,v,z,n)",
             tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] op
  );
    ina    = a;
    inb    = b;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n  = 1'b1;
    ina    = 4'b1010;
    inb    = 4'b0110;
    opcode = 3'b000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async", 4'b0000, 0, 0, 1, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_hold", 4'b0000, 0, 0, 1, 0);
    rst_n = 1'b1;

    drive(4'b1001, 4'b0001, 3'b000);
    chk("first_add", 4'b1010, 0, 0, 0, 1);
    drive(4'b1001, 4'b0001, 3'b001);
    chk("sub", 4'b1000, 0, 0, 0, 1);
    drive(4'b1001, 4'b0001, 3'b010);
    chk("and", 4'b0001, 0, 0, 0, 0);
    drive(4'b1001, 4'b0001, 3'b011);
    chk("or", 4'b1001, 0, 0, 0, 1);
    drive(4'b1001, 4'b0001, 3'b100);
    chk("xor", 4'b1000, 0, 0, 0, 1);
    drive(4'b1001, 4'b0001, 3'b101);
    chk("not", 4'b0110, 0, 0, 0, 0);
    drive(4'b1001, 4'b0001, 3'b110);
    chk("shl", 4'b0010, 1, 0, 0, 0);
    drive(4'b1001, 4'b0001, 3'b111);
    chk("shr", 4'b0100, 1, 0, 0, 0);

    drive(4'b0111, 4'b0101, 3'b000);
    chk("add_ovf", 4'b1100, 0, 1, 0, 1);
    drive(4'b0111, 4'b0101, 3'b001);
    chk("sub_pos", 4'b0010, 0, 0, 0, 0);
    drive(4'b0001, 4'b0011, 3'b001);
    chk("sub_borrow", 4'b1110, 1, 0, 0, 1);
    drive(4'b1111, 4'b0001, 3'b000);
    chk("add_wrap_zero", 4'b0000, 1, 0, 1, 0);
    drive(4'b1000, 4'b0001, 3'b001);
    chk("sub_ovf", 4'b0111, 0, 1, 0, 0);
    drive(4'b1000, 4'b1000, 3'b000);
    chk("add_neg_ovf", 4'b0000, 1, 1, 1, 0);
    drive(4'b1001, 4'b1111, 3'b101);
    chk("not_ign_b", 4'b0110, 0, 0, 0, 0);
    drive(4'b0110, 4'b1111, 3'b111);
    chk("shr_ign_b", 4'b0011, 0, 0, 0, 0);
    drive(4'b0101, 4'b1010, 3'b010);
    chk("and_zero", 4'b0000, 0, 0, 1, 0);

    drive(4'b0111, 4'b0101, 3'b000);
    chk("pre_reset", 4'b1100, 0, 1, 0, 1);
    ina    = 4'b1111;
    inb    = 4'b1111;
    opcode = 3'b011;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_async", 4'b0000, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("mid_reset_hold", 4'b0000, 0, 0, 1, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_or", 4'b1111, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
